// File: rtl/anomaly_alarm_aggregator_if.sv
// Detector-to-aggregator bundle: scored samples and threshold in,
// windowed count, alarm and timestamp out.
interface anomaly_alarm_aggregator_if #(
    parameter int CNT_W = 5,
    parameter int TS_W  = 16
);
    logic             score_valid;
    logic             anomaly_detected;
    logic [CNT_W-1:0] threshold;
    logic             alarm_ack;
    logic [CNT_W-1:0] anomaly_count;
    logic             alarm;
    logic             alarm_pulse;
    logic [TS_W-1:0]  alarm_timestamp;
    logic [TS_W-1:0]  sample_index;
    logic [1:0]       state;

    modport master (
        output score_valid, anomaly_detected, threshold, alarm_ack,
        input  anomaly_count, alarm, alarm_pulse,
        input  alarm_timestamp, sample_index, state
    );

    modport slave (
        input  score_valid, anomaly_detected, threshold, alarm_ack,
        output anomaly_count, alarm, alarm_pulse,
        output alarm_timestamp, sample_index, state
    );
endinterface

// File: rtl/anomaly_alarm_aggregator.sv
// Sliding-window anomaly counter with latched, acknowledged alarm
// and a sample-counted hold-off that suppresses alarm storms.
module anomaly_alarm_aggregator #(
    parameter int WINDOW  = 16,
    parameter int CNT_W   = 5,
    parameter int TS_W    = 16,
    parameter int HOLDOFF = 8
) (
    input logic                      clk,
    input logic                      reset,
    anomaly_alarm_aggregator_if.slave bus
);
    localparam int HC_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HC_W-1:0] HC_LOAD = HC_W'(HOLDOFF);

    typedef enum logic [1:0] {
        S_MONITOR = 2'd0,
        S_ALARM   = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WINDOW-1:0] hist_q, hist_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_next;
    logic [TS_W-1:0]   idx_q, idx_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [HC_W-1:0]   hc_q, hc_d;
    logic              alarm_q, alarm_d;
    logic              pulse_q, pulse_d;
    logic              accept, trig;

    // Window update, trigger detection and FSM next-state.
    always_comb begin
        accept   = bus.score_valid;
        cnt_next = cnt_q + CNT_W'(bus.anomaly_detected)
                 - CNT_W'(hist_q[WINDOW-1]);
        trig     = accept && (bus.threshold != '0)
                 && (cnt_next >= bus.threshold);
        state_d  = state_q;
        hist_d   = hist_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        ts_d     = ts_q;
        hc_d     = hc_q;
        alarm_d  = alarm_q;
        pulse_d  = 1'b0;
        if (accept) begin
            hist_d = {hist_q[WINDOW-2:0], bus.anomaly_detected};
            cnt_d  = cnt_next;
            idx_d  = idx_q + TS_W'(1);
        end
        unique case (state_q)
            S_MONITOR: begin
                if (trig) begin
                    state_d = S_ALARM;
                    alarm_d = 1'b1;
                    pulse_d = 1'b1;
                    ts_d    = idx_q;
                end
            end
            S_ALARM: begin
                if (bus.alarm_ack) begin
                    alarm_d = 1'b0;
                    hc_d    = HC_LOAD;
                    state_d = (HOLDOFF == 0) ? S_MONITOR : S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (accept) begin
                    hc_d = hc_q - HC_W'(1);
                    if (hc_q <= HC_W'(1))
                        state_d = S_MONITOR;
                end
            end
            default: state_d = S_MONITOR;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_MONITOR;
            hist_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            ts_q    <= '0;
            hc_q    <= '0;
            alarm_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ts_q    <= ts_d;
            hc_q    <= hc_d;
            alarm_q <= alarm_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.anomaly_count   = cnt_q;
    assign bus.alarm           = alarm_q;
    assign bus.alarm_pulse     = pulse_q;
    assign bus.alarm_timestamp = ts_q;
    assign bus.sample_index    = idx_q;
    assign bus.state           = state_q;
endmodule

// File: doc/anomaly_alarm_aggregator.md
Name: anomaly_alarm_aggregator

Overview:
Downstream stage of the anomaly detection system. Consumes the per-sample anomaly_detected verdict from the isolation-tree detector and counts anomalies over a sliding window of the last WINDOW scored samples. Raises a latched alarm, with a timestamp, when the count reaches a programmable threshold. The alarm is held until acknowledged, then followed by a sample-counted hold-off, so isolated outliers do not trigger alarms and alarm storms are suppressed.

Parameters:
WINDOW, 16, sliding-window length in scored samples; legal range 2..64.
CNT_W, 5, width of the count and threshold; must satisfy 2^CNT_W > WINDOW.
TS_W, 16, width of the sample index and timestamp.
HOLDOFF, 8, scored samples to ignore after acknowledge; 0 is legal.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low reset.
score_valid  in  1  one-cycle strobe; the detector verdict is valid this cycle.
anomaly_detected  in  1  detector verdict, sampled only when score_valid=1.
threshold  in  CNT_W  alarm threshold; 0 disables alarming.
alarm_ack  in  1  acknowledge from host or controller; level-sampled.
anomaly_count  out  CNT_W  anomalies among the last WINDOW accepted samples.
alarm  out  1  latched alarm level.
alarm_pulse  out  1  one-cycle strobe on alarm rise.
alarm_timestamp  out  TS_W  sample_index of the sample that triggered the alarm.
sample_index  out  TS_W  count of accepted samples.
state  out  2  FSM state: 0=MONITOR, 1=ALARM, 2=HOLDOFF.

Behaviour:
- Reset (sampled at a clk edge with reset=0) clears everything:
  - history, anomaly_count, sample_index, alarm_timestamp, holdoff counter all 0;
  - alarm=0, alarm_pulse=0, state=MONITOR.
  - Applies mid-operation; takes effect at the next edge, overriding all other inputs.
- Accept: a sample is accepted on an edge where score_valid=1. Nothing changes on edges with score_valid=0, except:
  - the FSM ack path;
  - alarm_pulse clearing.
- History is a WINDOW-bit shift register. On accept:
  - hist <= {hist[WINDOW-2:0], anomaly_detected};
  - cnt_next = anomaly_count + anomaly_detected - hist[WINDOW-1], registered into anomaly_count.
  - Count never exceeds WINDOW or underflows.
  - Warm-up needs no special case: history starts at zero.
- sample_index increments on every accept and wraps from 2^TS_W-1 to 0.
  - The index of the accepted sample is the pre-increment value.
- Trigger condition: accept AND threshold!=0 AND cnt_next >= threshold, evaluated combinationally on the accept edge.
  - threshold is sampled at that edge.
- MONITOR:
  - On trigger, go to ALARM. Set alarm=1 and alarm_pulse=1, and capture alarm_timestamp=sample_index (pre-increment value).
  - Latency: trigger accepted at edge t, so alarm is visible after edge t, one cycle after the strobe.
  - alarm_ack is ignored in MONITOR.
- ALARM:
  - alarm held at 1; alarm_pulse cleared after one cycle.
  - Window and count keep updating; further triggers do not re-pulse and do not move the timestamp.
  - alarm_ack=1 at an edge: alarm <= 0, holdoff counter <= HOLDOFF, go to HOLDOFF. If HOLDOFF=0, go directly to MONITOR.
  - Ack and trigger on the same edge: ack wins.
- HOLDOFF:
  - Each accept decrements the counter, and the window still updates.
  - When the counter reaches 0 on an accept, go to MONITOR.
  - Triggers during HOLDOFF are discarded. The first trigger check in MONITOR occurs on the next accept after returning; a still-high count then re-alarms immediately.
  - alarm_ack is ignored.
- Changing threshold in ALARM or HOLDOFF has no effect until MONITOR.
- threshold > WINDOW means the alarm can never fire. This is legal.
- Outputs are all registered; no combinational path from input to output.

Test Plan:
- WINDOW=16, threshold=4, 10 accepts carrying 3 anomalies -> anomaly_count=3, alarm stays 0, sample_index=10.
- Continue with a 4th anomaly as sample index 10 -> alarm=1 next cycle, alarm_pulse high exactly 1 cycle, alarm_timestamp=10, state=1.
- Slide-out: 16 accepts with only sample 0 anomalous, then 1 clean accept -> count goes 1 then 0. The dropped bit is subtracted on the same edge a new anomalous bit is added (count unchanged).
- Ack and hold-off, HOLDOFF=8, count held ≥ threshold -> ack drops alarm next cycle, state=2. 7 accepts keep state=2. The 8th accept returns to MONITOR with no alarm; the 9th accept re-raises alarm with the new timestamp.
- Corner: ack and triggering accept on the same edge in ALARM -> state=2, alarm=0. threshold=0 with 16 anomalous accepts -> alarm never asserts, count=16.
- Reset mid-ALARM with score_valid=1 on the same edge -> all outputs 0 after that edge, sample_index=0; sample_index wraps 65535 to 0 with TS_W=16.
